// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
//   Shares one 4-digit seven-segment driver among three display sources.
//   Source 2 (alert) preempts everything. Sources 0 (answer) and 1 (score)
//   take turns round-robin. Every grant is held for at least HOLD_CYCLES
//   clocks so the display does not flicker.
//
//   Optional feature macro: DISP_ARB_GAP_EN
//     When defined, every switch between two different sources passes
//     through a blank GAP of GAP_CYCLES clocks. When undefined, switches are
//     direct and GAP_CYCLES has no effect.
//
// Parameters
//   HOLD_CYCLES  minimum dwell per grant, in clk cycles (>= 1)
//   GAP_CYCLES   blank interval between sources, in clk cycles (>= 1)
//
// Ports
//   IN_clk          clock, all state changes on the rising edge
//   IN_reset        synchronous active-high reset
//   IN_req[2:0]     level-sensitive request, bit n = source n
//   IN_srcN_digits  28-bit pattern bus {digit3,digit2,digit1,digit0}, 7 bits
//                   each, active-low cathodes
//   OUT_digit0..3   registered pattern for the display driver (7'h7F = blank)
//   OUT_grant[2:0]  one-hot owner, 000 when nobody owns the display
//   OUT_busy        high while a source is granted or a gap is running
module seg_display_arbiter #(
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int GAP_CYCLES  = 5_000_000
) (
  input  logic        IN_clk,
  input  logic        IN_reset,
  input  logic [2:0]  IN_req,
  input  logic [27:0] IN_src0_digits,
  input  logic [27:0] IN_src1_digits,
  input  logic [27:0] IN_src2_digits,
  output logic [6:0]  OUT_digit0,
  output logic [6:0]  OUT_digit1,
  output logic [6:0]  OUT_digit2,
  output logic [6:0]  OUT_digit3,
  output logic [2:0]  OUT_grant,
  output logic        OUT_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam int              HW       = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0]   HOLD_MAX = HW'(HOLD_CYCLES - 1);
  localparam logic [27:0]     BLANK    = {4{7'h7F}};

  state_t          state, state_d;
  logic [1:0]      owner, owner_d;
  logic [HW-1:0]   hold_cnt, hold_d;
  logic            rr_last, rr_d;     // 0 = source 0 granted last, 1 = source 1

`ifdef DISP_ARB_GAP_EN
  localparam int            GW      = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYCLES - 1);
  logic [GW-1:0]  gap_cnt, gap_d;
`endif

  logic        pick_valid;
  logic [1:0]  pick_src;
  logic        take;           // grant pick_src on this edge
  logic        change;         // leave the current owner for a different one

  logic [2:0]  grant_d;
  logic        busy_d;
  logic [27:0] digits_d, digits_q;

  // Pick: source 2 first, then 0/1 with the tie going to whoever was not
  // granted last.
  always_comb begin
    pick_valid = 1'b1;
    pick_src   = 2'd0;
    if (IN_req[2])                   pick_src = 2'd2;
    else if (IN_req[0] && IN_req[1]) pick_src = rr_last ? 2'd0 : 2'd1;
    else if (IN_req[0])              pick_src = 2'd0;
    else if (IN_req[1])              pick_src = 2'd1;
    else                             pick_valid = 1'b0;
  end

  // Next-state logic.
  // NOTE: every signal written in a combinational block gets a default at
  // the top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    owner_d = owner;
    hold_d  = hold_cnt;
    rr_d    = rr_last;
    take    = 1'b0;
    change  = 1'b0;
`ifdef DISP_ARB_GAP_EN
    gap_d   = gap_cnt;
`endif

    case (state)
      S_IDLE: begin
        if (pick_valid) take = 1'b1;
      end
      S_GRANT: begin
        if (IN_req[2] && owner != 2'd2) change = 1'b1;       // preemption
        else if (hold_cnt != HOLD_MAX)  hold_d = hold_cnt + HW'(1);
        else if (!pick_valid)           state_d = S_IDLE;
        else if (pick_src != owner)     change = 1'b1;
        // pick == owner: stay, hold_cnt remains saturated
      end
`ifdef DISP_ARB_GAP_EN
      S_GAP: begin
        // The gap always runs to completion; pick is re-evaluated at its end.
        if (gap_cnt != GAP_MAX) gap_d = gap_cnt + GW'(1);
        else if (pick_valid)    take = 1'b1;
        else                    state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (change) begin
`ifdef DISP_ARB_GAP_EN
      state_d = S_GAP;
      gap_d   = '0;
`else
      take = 1'b1;
`endif
    end

    if (take) begin
      state_d = S_GRANT;
      owner_d = pick_src;
      hold_d  = '0;
      if (pick_src != 2'd2) rr_d = pick_src[0];
    end
  end

  // Output values for the upcoming state, registered together with it so
  // grant, busy and digits always agree.
  always_comb begin
    grant_d  = 3'b000;
    busy_d   = 1'b0;
    digits_d = BLANK;
    if (state_d == S_GRANT) begin
      busy_d = 1'b1;
      case (owner_d)
        2'd0:    begin grant_d = 3'b001; digits_d = IN_src0_digits; end
        2'd1:    begin grant_d = 3'b010; digits_d = IN_src1_digits; end
        default: begin grant_d = 3'b100; digits_d = IN_src2_digits; end
      endcase
    end else if (state_d == S_GAP) begin
      busy_d = 1'b1;
    end
  end

  // State and output registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge IN_clk) begin
    if (IN_reset) begin
      state     <= S_IDLE;
      owner     <= 2'd0;
      hold_cnt  <= '0;
      rr_last   <= 1'b1;          // source 0 wins the first 0/1 tie
`ifdef DISP_ARB_GAP_EN
      gap_cnt   <= '0;
`endif
      OUT_grant <= 3'b000;
      OUT_busy  <= 1'b0;
      digits_q  <= BLANK;
    end else begin
      state     <= state_d;
      owner     <= owner_d;
      hold_cnt  <= hold_d;
      rr_last   <= rr_d;
`ifdef DISP_ARB_GAP_EN
      gap_cnt   <= gap_d;
`endif
      OUT_grant <= grant_d;
      OUT_busy  <= busy_d;
      digits_q  <= digits_d;
    end
  end

  assign OUT_digit3 = digits_q[27:21];
  assign OUT_digit2 = digits_q[20:14];
  assign OUT_digit1 = digits_q[13:7];
  assign OUT_digit0 = digits_q[6:0];

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with HOLD_CYCLES=4, GAP_CYCLES=2.
// A table of per-cycle {reset, req, expected grant, expected busy} rows is
// applied one clock per row; expected digits follow from the expected owner.
// A hand-written sequence then checks 1-cycle pass-through of source data.
module tb_seg_display_arbiter;

  localparam int HOLD = 4;
  localparam int GAP  = 2;

  logic        IN_clk;
  logic        IN_reset;
  logic [2:0]  IN_req;
  logic [27:0] IN_src0_digits, IN_src1_digits, IN_src2_digits;
  logic [6:0]  OUT_digit0, OUT_digit1, OUT_digit2, OUT_digit3;
  logic [2:0]  OUT_grant;
  logic        OUT_busy;

  seg_display_arbiter #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .IN_clk         (IN_clk),
    .IN_reset       (IN_reset),
    .IN_req         (IN_req),
    .IN_src0_digits (IN_src0_digits),
    .IN_src1_digits (IN_src1_digits),
    .IN_src2_digits (IN_src2_digits),
    .OUT_digit0     (OUT_digit0),
    .OUT_digit1     (OUT_digit1),
    .OUT_digit2     (OUT_digit2),
    .OUT_digit3     (OUT_digit3),
    .OUT_grant      (OUT_grant),
    .OUT_busy       (OUT_busy)
  );

  initial IN_clk = 1'b0;
  always #5 IN_clk = ~IN_clk;

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic [2:0] grant;
    logic       busy;
  } vec_t;

  localparam logic [27:0] SRC0  = {7'h40, 7'h79, 7'h24, 7'h30};
  localparam logic [27:0] SRC1  = {7'h19, 7'h12, 7'h02, 7'h78};
  localparam logic [27:0] SRC2  = {7'h00, 7'h10, 7'h08, 7'h03};
  localparam logic [27:0] NEW0  = {7'h06, 7'h5B, 7'h4F, 7'h66};
  localparam logic [27:0] BLANK = {4{7'h7F}};

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic add(input logic rst, input logic [2:0] req,
                     input logic [2:0] grant, input logic busy, input int n);
    vec_t v;
    v.rst = rst; v.req = req; v.grant = grant; v.busy = busy;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [27:0] act,
                       input logic [27:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [27:0] digits_for(input logic [2:0] g);
    case (g)
      3'b001:  return SRC0;
      3'b010:  return SRC1;
      3'b100:  return SRC2;
      default: return BLANK;
    endcase
  endfunction

  function automatic logic [27:0] out_digits();
    return {OUT_digit3, OUT_digit2, OUT_digit1, OUT_digit0};
  endfunction

  initial begin
    IN_reset       = 1'b1;
    IN_req         = 3'b000;
    IN_src0_digits = SRC0;
    IN_src1_digits = SRC1;
    IN_src2_digits = SRC2;

    // ---- vector table ------------------------------------------------
    add(1, 3'b111, 3'b000, 0, 2);   // reset wins over requests
`ifdef DISP_ARB_GAP_EN
    add(0, 3'b011, 3'b001, 1, 4);   // rr: source 0 first
    add(0, 3'b011, 3'b000, 1, 2);   // blank gap, busy high
    add(0, 3'b011, 3'b010, 1, 4);   // then source 1
    add(0, 3'b111, 3'b000, 1, 2);   // hold expiry + req2 -> gap
    add(0, 3'b100, 3'b100, 1, 1);   // source 2 at gap end
    add(0, 3'b000, 3'b100, 1, 3);
    add(0, 3'b000, 3'b000, 0, 1);
    add(0, 3'b001, 3'b001, 1, 1);   // preemption mid-hold, through gap
    add(0, 3'b101, 3'b000, 1, 1);
    add(0, 3'b100, 3'b000, 1, 1);   // gap not interrupted
    add(0, 3'b100, 3'b100, 1, 1);
    add(0, 3'b000, 3'b100, 1, 3);
    add(0, 3'b000, 3'b000, 0, 1);
`else
    add(0, 3'b111, 3'b100, 1, 1);   // first edge after release
    add(0, 3'b000, 3'b100, 1, 3);   // single sample held 4 cycles
    add(0, 3'b000, 3'b000, 0, 1);
    add(0, 3'b011, 3'b001, 1, 4);   // round-robin 001x4 010x4 001x4
    add(0, 3'b011, 3'b010, 1, 4);
    add(0, 3'b011, 3'b001, 1, 4);
    add(0, 3'b000, 3'b000, 0, 1);
    add(0, 3'b001, 3'b001, 1, 1);   // preemption after 1 cycle
    add(0, 3'b101, 3'b100, 1, 1);
    add(0, 3'b001, 3'b100, 1, 3);   // req2 dropped, still held
    add(0, 3'b001, 3'b001, 1, 1);   // back to source 0
    add(0, 3'b000, 3'b001, 1, 3);
    add(0, 3'b000, 3'b000, 0, 1);
    add(0, 3'b001, 3'b001, 1, 1);   // early drop
    add(0, 3'b000, 3'b001, 1, 3);
    add(0, 3'b000, 3'b000, 0, 1);
    add(0, 3'b011, 3'b010, 1, 3);   // rr_last=0 -> source 1, hold 0..2
    add(1, 3'b011, 3'b000, 0, 1);   // reset mid-grant
    add(0, 3'b011, 3'b001, 1, 4);   // rr_last back to 1 -> source 0
    add(0, 3'b011, 3'b010, 1, 4);
    add(0, 3'b111, 3'b100, 1, 1);   // req2 at hold expiry wins
    add(0, 3'b000, 3'b100, 1, 3);
    add(0, 3'b000, 3'b000, 0, 1);
`endif

    foreach (vecs[i]) begin
      @(negedge IN_clk);
      IN_reset = vecs[i].rst;
      IN_req   = vecs[i].req;
      @(posedge IN_clk);
      #1;
      check($sformatf("row%0d grant", i), {25'd0, OUT_grant}, {25'd0, vecs[i].grant});
      check($sformatf("row%0d busy", i),  {27'd0, OUT_busy},  {27'd0, vecs[i].busy});
      check($sformatf("row%0d digits", i), out_digits(), digits_for(vecs[i].grant));
    end

    // ---- pass-through latency of a granted source --------------------
    @(negedge IN_clk);
    IN_req = 3'b001;
    @(posedge IN_clk);
    #1;
    check("pt grant", {25'd0, OUT_grant}, 28'h1);
    check("pt old digits", out_digits(), SRC0);
    @(negedge IN_clk);
    IN_req         = 3'b000;
    IN_src0_digits = NEW0;
    #1;
    check("pt before edge", out_digits(), SRC0);
    @(posedge IN_clk);
    #1;
    check("pt new digits", out_digits(), NEW0);
    repeat (2) @(posedge IN_clk);
    #1;
    check("pt still held", {25'd0, OUT_grant}, 28'h1);
    @(posedge IN_clk);
    #1;
    check("pt released grant", {25'd0, OUT_grant}, 28'h0);
    check("pt released digits", out_digits(), BLANK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
